// File: rtl/instr_reg_param_if.sv
// Fetch-side bus of the instruction register: word handshake, flush/advance control and decode outputs.
// Ports (master = fetch/consumer side, slave = instr_reg_param):
//   flush, in_data, in_valid, advance -> slave; in_ready, instr_valid, opcode, addr_a/b/c, imm_valid, op_a, op_b -> master.
interface instr_reg_param_if #(
    parameter int DATA_W  = 16,
    parameter int OPC_W   = 4,
    parameter int FIELD_W = 4
);
    logic                flush;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                advance;
    logic                instr_valid;
    logic [OPC_W-1:0]    opcode;
    logic [FIELD_W-1:0]  addr_a;
    logic [FIELD_W-1:0]  addr_b;
    logic [FIELD_W-1:0]  addr_c;
    logic                imm_valid;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;

    modport master (
        output flush, in_data, in_valid, advance,
        input  in_ready, instr_valid, opcode, addr_a, addr_b, addr_c,
               imm_valid, op_a, op_b
    );

    modport slave (
        input  flush, in_data, in_valid, advance,
        output in_ready, instr_valid, opcode, addr_a, addr_b, addr_c,
               imm_valid, op_a, op_b
    );
endinterface

// File: rtl/instr_reg_param.sv
// Purpose: parametrised instruction register with immediate-word capture FSM, opcode/field decode and gated operand buses.
// Latency: word accepted at edge N is decoded in cycle N+1; immediate instructions complete one cycle after the immediate word.
// Backpressure: in_ready only when EMPTY, WAIT_IMM, or FULL with advance; low during rst; flush discards the presented word.
// Ports: clk, rst (sync, active-high); bus (instr_reg_param_if.slave) carries flush, in_data/in_valid/in_ready,
//        advance, instr_valid, opcode, addr_a/b/c, imm_valid, op_a, op_b.
// Build option: define IR_SIGN_EXT_EN to make op_b of non-immediate instructions the sign-extended
//        {addr_b, addr_c}; undefined, op_b is zero-extended addr_b.
module instr_reg_param #(
    parameter int               DATA_W     = 16,
    parameter int               OPC_W      = 4,
    parameter int               FIELD_W    = 4,
    parameter logic [OPC_W-1:0] IMM_OPCODE = 4'hE
) (
    input  logic              clk,
    input  logic              rst,
    instr_reg_param_if.slave  bus
);

    generate
        if (DATA_W != OPC_W + 3 * FIELD_W) begin : g_bad_widths
            $error("instr_reg_param: DATA_W must equal OPC_W + 3*FIELD_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_WAIT_IMM = 2'd1,
        S_FULL     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   w_ir_nxt;
    logic [DATA_W-1:0]   w_imm_nxt;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_word_is_imm;
    logic                w_instr_valid;
    logic [OPC_W-1:0]    w_opcode;
    logic [FIELD_W-1:0]  w_addr_a;
    logic [FIELD_W-1:0]  w_addr_b;
    logic [FIELD_W-1:0]  w_addr_c;
    logic [DATA_W-1:0]   w_field_b;

    // Readiness is a pure function of state and advance; flush does not
    // lower it, it only cancels the accept below.
    assign w_in_ready    = !rst && ((r_state == S_EMPTY) || (r_state == S_WAIT_IMM) ||
                                    ((r_state == S_FULL) && bus.advance));
    assign w_accept      = bus.in_valid && w_in_ready && !bus.flush;
    assign w_word_is_imm = (bus.in_data[DATA_W-1 -: OPC_W] == IMM_OPCODE);

    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_imm_nxt   = r_imm;
        if (bus.flush) begin
            // IR/IMM deliberately keep their contents; only the state drops.
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY, S_FULL: begin
                    // FULL only reloads when the consumer advances; an accept
                    // in FULL implies advance, giving the no-bubble handover.
                    if (w_accept) begin
                        w_ir_nxt = bus.in_data;
                        if (w_word_is_imm) begin
                            w_state_nxt = S_WAIT_IMM;
                        end else begin
                            w_state_nxt = S_FULL;
                            w_imm_nxt   = '0;
                        end
                    end else if ((r_state == S_FULL) && bus.advance) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_WAIT_IMM: begin
                    if (w_accept) begin
                        w_imm_nxt   = bus.in_data;
                        w_state_nxt = S_FULL;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_ir    <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_imm   <= w_imm_nxt;
        end
    end

    assign w_instr_valid = (r_state == S_FULL);
    assign w_opcode      = r_ir[DATA_W-1 -: OPC_W];
    assign w_addr_a      = r_ir[3*FIELD_W-1 -: FIELD_W];
    assign w_addr_b      = r_ir[2*FIELD_W-1 -: FIELD_W];
    assign w_addr_c      = r_ir[FIELD_W-1:0];

`ifdef IR_SIGN_EXT_EN
    // {addr_b, addr_c} forms a short signed literal; addr_b's MSB is the sign.
    assign w_field_b = {{(DATA_W-2*FIELD_W){w_addr_b[FIELD_W-1]}}, w_addr_b, w_addr_c};
`else
    assign w_field_b = {{(DATA_W-FIELD_W){1'b0}}, w_addr_b};
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.instr_valid = w_instr_valid;
    assign bus.opcode      = w_opcode;
    assign bus.addr_a      = w_addr_a;
    assign bus.addr_b      = w_addr_b;
    assign bus.addr_c      = w_addr_c;
    assign bus.imm_valid   = w_instr_valid && (w_opcode == IMM_OPCODE);
    // Operand buses read zero unless a complete instruction is held.
    assign bus.op_a        = w_instr_valid ? {{(DATA_W-FIELD_W){1'b0}}, w_addr_a} : '0;
    assign bus.op_b        = !w_instr_valid ? '0 :
                             (w_opcode == IMM_OPCODE) ? r_imm : w_field_b;

endmodule

// File: doc/instr_reg_param.md
# instr_reg_param

Parametrised instruction register with an immediate-word capture FSM and a valid/ready fetch handshake. It sits between the instruction memory read port and the control unit / register-file address muxes, and replaces the fixed 16-bit IR. It decodes opcode and three register-address fields. It captures an optional second (immediate) word, and presents operand buses only while a complete instruction is held.

## Interface
- DATA_W, 16, instruction/data word width
- OPC_W, 4, opcode field width (top bits of the word)
- FIELD_W, 4, width of each address field; DATA_W must equal OPC_W + 3*FIELD_W (elaboration error otherwise)
- IMM_OPCODE, 4'hE, opcode value whose instruction is followed by one immediate word
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard held/partial instruction (branch taken)
- in_data  input  DATA_W  word from instruction memory
- in_valid  input  1  in_data holds a word
- in_ready  output  1  block accepts in_data this cycle
- advance  input  1  consumer has finished with the current instruction
- instr_valid  output  1  complete instruction held; all decode outputs meaningful
- opcode  output  OPC_W  IR[DATA_W-1 -: OPC_W]
- addr_a / addr_b / addr_c  output  FIELD_W each  IR fields, MSB to LSB below the opcode
- imm_valid  output  1  held instruction carries an immediate
- op_a  output  DATA_W  zero-extended addr_a
- op_b  output  DATA_W  immediate word if imm_valid, else field-derived value (see Configuration)

## Operation
- Registers: IR (DATA_W), IMM (DATA_W), state.
- States:
  - EMPTY: nothing held.
  - WAIT_IMM: IR holds an IMM_OPCODE word; immediate not yet received.
  - FULL: instruction complete.
- Transfer: a word is accepted when in_valid && in_ready.
- in_ready = !rst && (state==EMPTY || state==WAIT_IMM || (state==FULL && advance)).
- EMPTY, word accepted:
  - IR <= word.
  - If word's opcode == IMM_OPCODE, go to WAIT_IMM.
  - Otherwise go to FULL with IMM <= 0.
- WAIT_IMM, word accepted: IMM <= word; go to FULL.
- FULL:
  - advance without an accepted word: go to EMPTY.
  - advance with an accepted word: load exactly as from EMPTY in the same cycle (back-to-back, no bubble).
  - No advance: hold IR, IMM and state.
- advance in EMPTY or WAIT_IMM is ignored.
- flush: go to EMPTY; any word presented that cycle is NOT accepted (in_ready is still computed from state, but the accept is discarded). IR and IMM keep their values.
- Priority: rst > flush > load/advance.
- instr_valid = (state==FULL).
- imm_valid = instr_valid && opcode==IMM_OPCODE.
- When instr_valid=0: op_a, op_b, imm_valid read 0. No tri-state values are driven; addr fields still mirror IR.

## Timing
- Reset values:
  - IR=0, IMM=0, state=EMPTY.
  - instr_valid=0, imm_valid=0, op_a=0, op_b=0, opcode/addr_*=0.
  - in_ready=0 while rst is high and 1 on the first cycle after.
- Latency: a word accepted at edge N is visible on decode outputs after edge N.
  - Non-immediate instruction: instr_valid=1 in cycle N+1.
  - Immediate instruction: instr_valid=1 one cycle after the immediate word is accepted.
- Throughput:
  - 1 instruction/cycle for non-immediate instructions under continuous advance and in_valid.
  - 1 per 2 cycles for immediate instructions.
- All outputs except in_ready are functions of registered state only. in_ready combinationally depends on advance and rst.
- rst or flush during WAIT_IMM: the partial instruction is dropped. The next accepted word is treated as a new first word, even if it was intended as the immediate.

## Configuration
- Macro IR_SIGN_EXT_EN.
- Defined: for non-immediate instructions, op_b = sign-extension of {addr_b, addr_c} (2*FIELD_W bits, MSB of addr_b is the sign) to DATA_W.
- Undefined: for non-immediate instructions, op_b = zero-extended addr_b.
- Immediate instructions, op_a, and all timing are identical in both builds.

## Test plan
- Reset then plain load: rst 2 cycles, in_data=16'h1234 with in_valid=1 -> next cycle:
  - instr_valid=1, opcode=1, addr_a=2, addr_b=3, addr_c=4.
  - op_a=16'h0002; op_b=16'h0003 (macro off) / 16'h0034 (macro on).
- Immediate pair: 16'hE120 then 16'hBEEF, each with in_valid=1 -> after the second edge:
  - instr_valid=1, imm_valid=1, op_b=16'hBEEF.
  - instr_valid=0 in the cycle between the two words.
- Back-to-back: state FULL with advance=1 and in_valid=1 holding 16'h2345 -> in_ready=1, IR=16'h2345 next cycle, instr_valid stays 1 with no bubble.
- Stall: state FULL, advance=0, in_valid=1 -> in_ready=0; IR and outputs unchanged for 5 cycles.
- Flush mid-immediate: 16'hE100 accepted, then flush=1 with in_data=16'h0F00 -> state EMPTY, that word not accepted; a following 16'h3001 loads as a plain instruction (imm_valid=0).
- Sign extension (macro on): 16'h10F8 -> op_b=16'hFFF8. Same word with macro off -> op_b=16'h000F.
